guess_scorer: RTL and testbench

//   Scoring end of the code-guessing game: takes the 4-slot colour guess built by the guess-entry block,

---
 rtl/guess_scorer_pkg.sv | 18 +
 rtl/guess_scorer_slot_match_finder.sv | 23 ++
 rtl/guess_scorer.sv | 125 ++++++++++++
 tb/tb_guess_scorer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/guess_scorer_pkg.sv
// guess_scorer_pkg: shared widths, FSM encoding and slot extraction for the guess scorer.
package guess_scorer_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int COLOR_W   = 3;
    localparam int MAX_TRIES = 8;
    localparam int CODE_W    = NUM_SLOTS * COLOR_W;
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1);
    localparam int TRY_W     = $clog2(MAX_TRIES + 1);
    localparam int IDX_W     = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, EXACT, PARTIAL, REPORT} state_t;

    function automatic logic [COLOR_W-1:0] get_slot(input logic [CODE_W-1:0] vec, input int k);
        return vec[k*COLOR_W +: COLOR_W];
    endfunction

endpackage

// File: rtl/guess_scorer_slot_match_finder.sv
// slot_match_finder: lowest unclaimed secret slot holding a given colour, as found flag plus one-hot index.
module slot_match_finder
    import guess_scorer_pkg::*;
(
    input  logic [COLOR_W-1:0]   colour,
    input  logic [CODE_W-1:0]    secret,
    input  logic [NUM_SLOTS-1:0] mask,
    output logic                 found,
    output logic [NUM_SLOTS-1:0] onehot
);

    // Scan from the top down so the lowest matching slot is written last and wins.
    always_comb begin
        onehot = '0;
        for (int j = NUM_SLOTS - 1; j >= 0; j--)
            if (!mask[j] && get_slot(secret, j) == colour) begin
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        found = |onehot;
    end

endmodule

// File: rtl/guess_scorer.sv
// guess_scorer: sequential exact/partial scoring of a guess against the latched secret, with try count and win/lose.
module guess_scorer
    import guess_scorer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_game,
    input  logic [CODE_W-1:0] secret,
    input  logic              submit,
    input  logic [CODE_W-1:0] guess,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  exact,
    output logic [CNT_W-1:0]  partial,
    output logic [TRY_W-1:0]  tries,
    output logic              win,
    output logic              lose
);

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx;
    logic [CODE_W-1:0]    secret_q, guess_q;
    logic [NUM_SLOTS-1:0] used, matched, hit;
    logic [CNT_W-1:0]     exact_acc, partial_acc;
    logic [COLOR_W-1:0]   g_slot, s_slot;
    logic                 found, last, start;

    assign g_slot = get_slot(guess_q, int'(idx));
    assign s_slot = get_slot(secret_q, int'(idx));
    assign last   = idx == IDX_W'(NUM_SLOTS - 1);
    assign start  = submit && !win && !lose;
    assign busy   = state != IDLE;

    slot_match_finder u_finder (
        .colour (g_slot),
        .secret (secret_q),
        .mask   (used | matched),
        .found  (found),
        .onehot (hit)
    );

    always_ff @(posedge clk)
        if (!rst_n || new_game)
            state <= IDLE;
        else
            state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? EXACT : IDLE;
            EXACT:   state_next = last ? PARTIAL : EXACT;
            PARTIAL: state_next = last ? REPORT : PARTIAL;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            secret_q    <= '0;
            guess_q     <= '0;
            used        <= '0;
            matched     <= '0;
            idx         <= '0;
            exact_acc   <= '0;
            partial_acc <= '0;
            exact       <= '0;
            partial     <= '0;
            tries       <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            done        <= 1'b0;
        end else if (new_game) begin
            secret_q    <= secret;
            used        <= '0;
            matched     <= '0;
            idx         <= '0;
            exact_acc   <= '0;
            partial_acc <= '0;
            exact       <= '0;
            partial     <= '0;
            tries       <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        guess_q     <= guess;
                        used        <= '0;
                        matched     <= '0;
                        idx         <= '0;
                        exact_acc   <= '0;
                        partial_acc <= '0;
                    end
                EXACT: begin
                    if (g_slot == s_slot) begin
                        matched[idx] <= 1'b1;
                        used[idx]    <= 1'b1;
                        exact_acc    <= exact_acc + 1'b1;
                    end
                    idx <= last ? '0 : idx + 1'b1;
                end
                PARTIAL: begin
                    if (!matched[idx] && found) begin
                        used        <= used | hit;
                        partial_acc <= partial_acc + 1'b1;
                    end
                    idx <= last ? '0 : idx + 1'b1;
                end
                default: begin
                    exact   <= exact_acc;
                    partial <= partial_acc;
                    tries   <= tries + 1'b1;
                    done    <= 1'b1;
                    win     <= exact_acc == CNT_W'(NUM_SLOTS);
                    lose    <= exact_acc != CNT_W'(NUM_SLOTS) && (tries + 1'b1) == TRY_W'(MAX_TRIES);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_scorer.sv
// tb_guess_scorer: directed games; expected results queued at submit and checked by a monitor on each done.
module tb_guess_scorer;
    import guess_scorer_pkg::*;

    typedef struct packed {
        logic [CNT_W-1:0] exact;
        logic [CNT_W-1:0] partial;
        logic [TRY_W-1:0] tries;
        logic             win;
        logic             lose;
    } res_t;

    logic              clk = 1'b0, rst_n = 1'b0, new_game = 1'b0, submit = 1'b0;
    logic [CODE_W-1:0] secret = '0, guess = '0;
    logic              busy, done, win, lose;
    logic [CNT_W-1:0]  exact, partial;
    logic [TRY_W-1:0]  tries;

    res_t exp_q[$];
    int   vectors = 0, miscompares = 0, done_seen = 0;

    guess_scorer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .new_game (new_game),
        .secret   (secret),
        .submit   (submit),
        .guess    (guess),
        .busy     (busy),
        .done     (done),
        .exact    (exact),
        .partial  (partial),
        .tries    (tries),
        .win      (win),
        .lose     (lose)
    );

    always #5 clk = ~clk;

    function automatic logic [CODE_W-1:0] pk(int s3, int s2, int s1, int s0);
        return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    function automatic res_t mk(int e, int p, int t, int w, int l);
        res_t r;
        r.exact   = CNT_W'(e);
        r.partial = CNT_W'(p);
        r.tries   = TRY_W'(t);
        r.win     = 1'(w);
        r.lose    = 1'(l);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial forever begin
        res_t got, want;
        @(negedge clk);
        if (done) begin
            done_seen++;
            vectors++;
            got = {exact, partial, tries, win, lose};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got e=%0d p=%0d t=%0d w=%0d l=%0d, expected no done",
                         got.exact, got.partial, got.tries, got.win, got.lose);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL result: got e=%0d p=%0d t=%0d w=%0d l=%0d, expected e=%0d p=%0d t=%0d w=%0d l=%0d",
                             got.exact, got.partial, got.tries, got.win, got.lose,
                             want.exact, want.partial, want.tries, want.win, want.lose);
                end
            end
        end
    end

    task automatic start_game(input logic [CODE_W-1:0] s);
        secret   = s;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    task automatic play(input logic [CODE_W-1:0] g, input res_t e);
        int n;
        guess  = g;
        submit = 1'b1;
        step();
        submit = 1'b0;
        guess  = ~g;
        exp_q.push_back(e);
        chk("busy_after_accept", int'(busy), 1);
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) break;
        end
        chk("done_latency", n, 9);
        chk("busy_in_done_cycle", int'(busy), 0);
    endtask

    task automatic ignored_submit(input logic [CODE_W-1:0] g, input string name);
        int d0, t0;
        d0     = done_seen;
        t0     = int'(tries);
        guess  = g;
        submit = 1'b1;
        step();
        submit = 1'b0;
        chk({name, "_busy"}, int'(busy), 0);
        repeat (12) step();
        chk({name, "_no_done"}, done_seen, d0);
        chk({name, "_tries"}, int'(tries), t0);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, int'({busy, done, exact, partial, tries, win, lose}), 0);
    endtask

    initial begin
        int d0;
        repeat (3) step();
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        step();

        // Exact win on the first try; a win blocks further submits.
        start_game(pk(4, 3, 2, 1));
        play(pk(4, 3, 2, 1), mk(4, 0, 1, 1, 0));
        ignored_submit(pk(0, 0, 0, 0), "after_win");

        // All colours present, all misplaced.
        start_game(pk(2, 2, 1, 1));
        play(pk(1, 1, 2, 2), mk(0, 4, 1, 0, 0));

        // Duplicate guess colours consume each secret slot at most once.
        start_game(pk(3, 2, 1, 1));
        play(pk(1, 1, 2, 1), mk(1, 2, 1, 0, 0));

        // Eight non-winning guesses lose the game; a ninth is refused.
        start_game(pk(5, 6, 7, 0));
        for (int i = 0; i < MAX_TRIES; i++)
            play(pk(0, 5, 6, 7), mk(0, 4, i + 1, 0, i == MAX_TRIES - 1 ? 1 : 0));
        chk("lose_flag", int'(lose), 1);
        chk("win_flag_after_loss", int'(win), 0);
        chk("tries_at_max", int'(tries), MAX_TRIES);
        ignored_submit(pk(0, 5, 6, 7), "after_lose");

        // new_game aborts a scoring pass and clears game state.
        start_game(pk(4, 3, 2, 1));
        play(pk(1, 2, 3, 4), mk(0, 4, 1, 0, 0));
        d0     = done_seen;
        guess  = pk(4, 3, 2, 1);
        submit = 1'b1;
        step();
        submit = 1'b0;
        repeat (3) step();
        secret   = pk(1, 1, 1, 1);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_tries", int'(tries), 0);
        chk("abort_partial", int'(partial), 0);
        repeat (12) step();
        chk("abort_no_done", done_seen, d0);
        // Submit coinciding with new_game is dropped.
        guess    = pk(1, 1, 1, 1);
        new_game = 1'b1;
        submit   = 1'b1;
        step();
        new_game = 1'b0;
        submit   = 1'b0;
        chk("newgame_submit_busy", int'(busy), 0);
        play(pk(1, 1, 1, 1), mk(4, 0, 1, 1, 0));

        // Submit during scoring is not queued.
        start_game(pk(3, 2, 1, 1));
        d0     = done_seen;
        guess  = pk(1, 1, 2, 1);
        submit = 1'b1;
        step();
        submit = 1'b0;
        exp_q.push_back(mk(1, 2, 1, 0, 0));
        repeat (2) step();
        guess  = pk(3, 2, 1, 1);
        submit = 1'b1;
        step();
        submit = 1'b0;
        repeat (15) step();
        chk("busy_submit_one_done", done_seen, d0 + 1);

        // Reset in the middle of the partial pass.
        d0     = done_seen;
        guess  = pk(1, 1, 2, 1);
        submit = 1'b1;
        step();
        submit = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        check_all_zero("reset_mid_partial");
        rst_n = 1'b1;
        repeat (12) step();
        chk("reset_no_done", done_seen, d0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
